mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Sequences a single shared, pipelined main memory between I-cache and D-cache
//  for the WISC-FA24 cached pipeline. Serves I-miss block fills, D-miss block fills
//  and D-side write-through stores, one request at a time.
//  Drives the memory address/enable/write lines, steers returning words into the
//  requesting cache's data array, pulses the tag write, and raises the stall lines
//  that freeze the pipeline.
// PARAMETERS
//  AWIDTH   16  address width (byte address)
//  DWIDTH   16  data word width
//  MEM_LAT  4   memory read latency, in cycles, from issue to mem_data_valid
//  BLK_WDS  8   words per cache block (block = 16 B; base = addr & 16'hFFF0)
// PORTS
//  clk              in   1       clock
//  rst              in   1       synchronous reset, active-high
//  icache_miss      in   1       I-cache miss pending (level, held until tag written)
//  icache_miss_addr in   AWIDTH  I-miss address
//  dcache_miss      in   1       D-cache miss pending (level)
//  dcache_miss_addr in   AWIDTH  D-miss address
//  dcache_wr        in   1       D-side store request (write-through)
//  dcache_wr_addr   in   AWIDTH  store address
//  dcache_wr_data   in   DWIDTH  store data
//  mem_data_in      in   DWIDTH  read data from memory
//  mem_data_valid   in   1       mem_data_in valid this cycle
//  mem_addr         out  AWIDTH  memory address
//  mem_wdata        out  DWIDTH  memory write data
//  mem_en           out  1       memory access this cycle
//  mem_wr           out  1       memory access is a write
//  fill_data        out  DWIDTH  word to write into the cache data array (= mem_data_in)
//  fill_word_idx    out  3       word index within the block for fill_data
//  fill_i_we        out  1       write fill_data into the I-cache
//  fill_d_we        out  1       write fill_data into the D-cache
//  tag_i_we         out  1       write I-cache tag/valid (one-cycle pulse)
//  tag_d_we         out  1       write D-cache tag/valid (one-cycle pulse)
//  i_stall          out  1       freeze fetch
//  d_stall          out  1       freeze MEM and earlier stages
// BEHAVIOUR
//  - FSM states: IDLE, I_FILL, D_FILL, D_WRITE.
//  - Counters: issue_cnt and recv_cnt, each 0..BLK_WDS. Base address is latched on entry.
//  - Arbitration happens only in IDLE and is non-preemptive. Priority: dcache_wr > dcache_miss > icache_miss.
//  - Transitions:
//    - IDLE -> D_WRITE / D_FILL / I_FILL on the next edge after the winning request is sampled.
//    - D_WRITE: exactly 1 cycle. mem_en=1, mem_wr=1, mem_addr=dcache_wr_addr, mem_wdata=dcache_wr_data. Then -> IDLE.
//    - *_FILL issue: while issue_cnt<BLK_WDS, mem_en=1, mem_wr=0, mem_addr = base + 2*issue_cnt, issue_cnt++.
//    - *_FILL receive: each mem_data_valid sets fill_*_we=1 with fill_word_idx=recv_cnt, then recv_cnt++.
//    - The last word (recv_cnt==BLK_WDS-1) also pulses tag_*_we in the same cycle. Then -> IDLE.
//  - Timing: request sampled at cycle T; issues at T+1..T+8; data at T+1+MEM_LAT..T+8+MEM_LAT; back in IDLE at T+9+MEM_LAT.
//  - Stall lines:
//    - i_stall = icache_miss | (state==I_FILL).
//    - d_stall = dcache_miss | dcache_wr | (state in D_FILL, D_WRITE).
//    - Both are combinational, so a pending request stalls while it waits for arbitration.
//  - mem_data_valid outside a FILL state, or beyond BLK_WDS words, is ignored: no we, no counter change.
//  - The address offset adds 2*issue_cnt to a 16-byte-aligned base; no carry out of bit 3, so no wrap-around.
//  - Simultaneous requests: the loser keeps its stall high and is served at the next IDLE.
//    With I and D both missing, the D fill completes first, then the I fill starts.
//  - Idle outputs: mem_en, mem_wr, all we/tag pulses = 0; mem_addr and mem_wdata = 0; fill_word_idx = 0.
//  - Reset (any state, including mid-fill): next state IDLE, counters 0, latched base 0, all registered outputs 0.
//    In-flight read data after reset is dropped; no cache write occurs.
// TESTING
//  1. Lone I-miss, addr 0x0126 at T:
//     - mem reads 0x0120..0x012E at T+1..T+8.
//     - 8 fill_i_we with idx 0..7.
//     - tag_i_we only at T+12.
//     - i_stall drops once icache_miss drops.
//  2. I-miss and D-miss (addr 0x4008) asserted together:
//     - D fill of 0x4000..0x400E is served first, with i_stall held high throughout.
//     - I fill issues start the cycle after D returns to IDLE.
//  3. dcache_wr 0x2002 / 0xBEEF during an I fill:
//     - No memory write until the I fill completes.
//     - Then exactly one cycle with mem_en=1, mem_wr=1, addr 0x2002, data 0xBEEF.
//  4. Spurious mem_data_valid in IDLE, and a 9th valid during a fill:
//     - No fill_*_we, no tag pulse, counters unchanged.
//  5. rst asserted after the 3rd returned word of a D fill:
//     - Next cycle IDLE with all outputs 0.
//     - The remaining 5 returning words produce no we.
//     - A fresh miss is served from word 0.
//  6. MEM_LAT=1 build:
//     - The returned data overlaps issue.
//     - All 8 words land at idx 0..7 in order, with tag_*_we on the 8th.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one pipelined main memory between the I-cache and the D-cache.
// It serves three kinds of request, one at a time:
//   - I-miss block fills
//   - D-miss block fills
//   - D-side write-through stores
// A fill issues BLK_WDS sequential word reads from the block base. Returning
// words are steered into the requesting cache's data array. The tag/valid
// write is pulsed together with the last word.
//
// State table:
//   state   | meaning
//   IDLE    | no transfer; arbitrate pending requests (wr > d-miss > i-miss)
//   I_FILL  | issuing/receiving an I-cache block fill
//   D_FILL  | issuing/receiving a D-cache block fill
//   D_WRITE | single-cycle write-through store to memory
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   icache_miss/_addr             I-miss request (level) and address
//   dcache_miss/_addr             D-miss request (level) and address
//   dcache_wr/_addr/_data         store request, address, data
//   mem_data_in, mem_data_valid   read return from memory
//   mem_addr/wdata/en/wr          memory command
//   fill_data, fill_word_idx      word and index for the cache data arrays
//   fill_i_we, fill_d_we          data array write strobes
//   tag_i_we, tag_d_we            tag/valid write pulses
//   i_stall, d_stall              pipeline freeze lines
module mem_arbiter #(
  parameter int AWIDTH  = 16,
  parameter int DWIDTH  = 16,
  parameter int MEM_LAT = 4,
  parameter int BLK_WDS = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       icache_miss,
  input  logic [AWIDTH-1:0]          icache_miss_addr,
  input  logic                       dcache_miss,
  input  logic [AWIDTH-1:0]          dcache_miss_addr,
  input  logic                       dcache_wr,
  input  logic [AWIDTH-1:0]          dcache_wr_addr,
  input  logic [DWIDTH-1:0]          dcache_wr_data,
  input  logic [DWIDTH-1:0]          mem_data_in,
  input  logic                       mem_data_valid,
  output logic [AWIDTH-1:0]          mem_addr,
  output logic [DWIDTH-1:0]          mem_wdata,
  output logic                       mem_en,
  output logic                       mem_wr,
  output logic [DWIDTH-1:0]          fill_data,
  output logic [$clog2(BLK_WDS)-1:0] fill_word_idx,
  output logic                       fill_i_we,
  output logic                       fill_d_we,
  output logic                       tag_i_we,
  output logic                       tag_d_we,
  output logic                       i_stall,
  output logic                       d_stall
);

  localparam int IW = $clog2(BLK_WDS);
  localparam int CW = $clog2(BLK_WDS + 1);
  localparam logic [AWIDTH-1:0] BLK_MASK = ~AWIDTH'(2 * BLK_WDS - 1);

  // The sequencer does not depend on the read latency: it counts returned
  // words rather than timing them. Any latency of at least one cycle works.
  if (MEM_LAT < 1) begin : g_lat_check
    $error("mem_arbiter: MEM_LAT must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, I_FILL, D_FILL, D_WRITE} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     issue_cnt, recv_cnt;
  logic [AWIDTH-1:0] base;
  logic              issue_inc, recv_inc;
  logic              last_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      base      <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        issue_cnt <= '0;
        recv_cnt  <= '0;
        if (state_nxt == I_FILL)
          base <= icache_miss_addr & BLK_MASK;
        else if (state_nxt == D_FILL)
          base <= dcache_miss_addr & BLK_MASK;
      end else begin
        if (issue_inc) issue_cnt <= issue_cnt + CW'(1);
        if (recv_inc)  recv_cnt  <= recv_cnt + CW'(1);
      end
    end
  end

  assign last_word = (recv_cnt == CW'(BLK_WDS - 1));

  always_comb begin
    state_nxt     = state;
    issue_inc     = 1'b0;
    recv_inc      = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_en        = 1'b0;
    mem_wr        = 1'b0;
    fill_data     = mem_data_in;
    fill_word_idx = '0;
    fill_i_we     = 1'b0;
    fill_d_we     = 1'b0;
    tag_i_we      = 1'b0;
    tag_d_we      = 1'b0;

    case (state)
      IDLE: begin
        if (dcache_wr)        state_nxt = D_WRITE;
        else if (dcache_miss) state_nxt = D_FILL;
        else if (icache_miss) state_nxt = I_FILL;
      end

      D_WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = dcache_wr_addr;
        mem_wdata = dcache_wr_data;
        state_nxt = IDLE;
      end

      I_FILL, D_FILL: begin
        if (issue_cnt < CW'(BLK_WDS)) begin
          mem_en    = 1'b1;
          mem_addr  = base + AWIDTH'({issue_cnt, 1'b0});
          issue_inc = 1'b1;
        end
        // Cache-side strobes are suppressed during reset so that data
        // already in flight cannot reach a cache array.
        if (mem_data_valid && (recv_cnt < CW'(BLK_WDS))) begin
          recv_inc      = 1'b1;
          fill_word_idx = recv_cnt[IW-1:0];
          if (state == I_FILL) begin
            fill_i_we = ~rst;
            tag_i_we  = ~rst & last_word;
          end else begin
            fill_d_we = ~rst;
            tag_d_we  = ~rst & last_word;
          end
          if (last_word) state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Pending requests stall the pipeline while they wait for arbitration.
  assign i_stall = icache_miss | (state == I_FILL);
  assign d_stall = dcache_miss | dcache_wr | (state == D_FILL) | (state == D_WRITE);

endmodule
